// File: rtl/io_ring_pwr_seq.sv
// Power sequencer for the 1.8 V IO ring: ring enable, retention release and driver enable
// on power-up, reversed on power-down, with a sticky fault on loss of VDDQ.
module io_ring_pwr_seq #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned T_RING = 1000,
  parameter int unsigned T_RET  = 64,
  parameter int unsigned T_OE   = 16,
  parameter int unsigned T_TMO  = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_up_req,
  input  logic       pwr_dn_req,
  input  logic       vddq_ok_async,
  output logic       ring_en,
  output logic       ret_n,
  output logic       pad_oe_en,
  output logic       pwr_ack,
  output logic       pwr_fault,
  output logic [2:0] pwr_state
);

  localparam logic [2:0] StOff   = 3'd0;
  localparam logic [2:0] StRamp  = 3'd1;
  localparam logic [2:0] StRet   = 3'd2;
  localparam logic [2:0] StOn    = 3'd3;
  localparam logic [2:0] StDnOe  = 3'd4;
  localparam logic [2:0] StDnRet = 3'd5;
  localparam logic [2:0] StFault = 3'd6;

  localparam logic [CNT_W-1:0] TRingC = CNT_W'(T_RING);
  localparam logic [CNT_W-1:0] TRetC  = CNT_W'(T_RET);
  localparam logic [CNT_W-1:0] TOeC   = CNT_W'(T_OE);
  localparam logic [CNT_W-1:0] TTmoC  = CNT_W'(T_TMO);

  logic             sync_q, vddq_ok_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_nxt;
  logic             ring_en_d, ret_n_d, oe_d, ack_d, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b0;
      vddq_ok_s <= 1'b0;
    end else begin
      sync_q    <= vddq_ok_async;
      vddq_ok_s <= sync_q;
    end
  end

  // Saturating increments; a "reached" compare looks at the incremented value so a step
  // of T cycles leaves the state on the T-th edge after entry.
  assign cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign tmo_nxt = (&tmo_q) ? tmo_q : tmo_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_nxt;
    tmo_d   = tmo_nxt;
    case (state_q)
      StOff: begin
        if (pwr_up_req && !pwr_dn_req) state_d = StRamp;
      end
      StRamp: begin
        cnt_d = vddq_ok_s ? cnt_nxt : '0;
        if (pwr_dn_req)                          state_d = StOff;
        else if (vddq_ok_s && cnt_nxt == TRingC) state_d = StRet;
        else if (tmo_nxt == TTmoC)               state_d = StFault;
      end
      StRet: begin
        if (!vddq_ok_s)              state_d = StFault;
        else if (pwr_dn_req)         state_d = StDnRet;
        else if (cnt_nxt == TRetC)   state_d = StOn;
      end
      StOn: begin
        if (!vddq_ok_s)      state_d = StFault;
        else if (pwr_dn_req) state_d = StDnOe;
      end
      StDnOe: begin
        if (!vddq_ok_s)           state_d = StFault;
        else if (cnt_nxt == TOeC) state_d = StDnRet;
      end
      StDnRet: begin
        if (!vddq_ok_s)            state_d = StFault;
        else if (cnt_nxt == TRetC) state_d = StOff;
      end
      StFault: begin
        if (pwr_dn_req) state_d = StOff;
      end
      default: state_d = StOff;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end
  end

  // Outputs decode the next state so they move on the same edge as pwr_state.
  always_comb begin
    ring_en_d = 1'b0;
    ret_n_d   = 1'b0;
    oe_d      = 1'b0;
    ack_d     = 1'b0;
    fault_d   = 1'b0;
    case (state_d)
      StRamp:  ring_en_d = 1'b1;
      StRet: begin
        ring_en_d = 1'b1;
        ret_n_d   = 1'b1;
      end
      StOn: begin
        ring_en_d = 1'b1;
        ret_n_d   = 1'b1;
        oe_d      = 1'b1;
        ack_d     = 1'b1;
      end
      StDnOe: begin
        ring_en_d = 1'b1;
        ret_n_d   = 1'b1;
      end
      StDnRet: ring_en_d = 1'b1;
      StFault: fault_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      tmo_q     <= '0;
      ring_en   <= 1'b0;
      ret_n     <= 1'b0;
      pad_oe_en <= 1'b0;
      pwr_ack   <= 1'b0;
      pwr_fault <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      ring_en   <= ring_en_d;
      ret_n     <= ret_n_d;
      pad_oe_en <= oe_d;
      pwr_ack   <= ack_d;
      pwr_fault <= fault_d;
    end
  end

  assign pwr_state = state_q;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Scoreboard bench for io_ring_pwr_seq: expected state/output changes are queued with their
// cycle numbers and a monitor compares every change the DUT presents.
module tb_io_ring_pwr_seq;

  localparam logic [7:0] V_OFF   = 8'b000_00000;
  localparam logic [7:0] V_RAMP  = 8'b001_10000;
  localparam logic [7:0] V_RET   = 8'b010_11000;
  localparam logic [7:0] V_ON    = 8'b011_11110;
  localparam logic [7:0] V_DNOE  = 8'b100_11000;
  localparam logic [7:0] V_DNRET = 8'b101_10000;
  localparam logic [7:0] V_FAULT = 8'b110_00001;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, pwr_up_req, pwr_dn_req, vddq_ok_async;
  logic       ring_en, ret_n, pad_oe_en, pwr_ack, pwr_fault;
  logic [2:0] pwr_state;
  logic [7:0] obs;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       q[$];

  io_ring_pwr_seq #(
    .CNT_W (16),
    .T_RING(8),
    .T_RET (4),
    .T_OE  (2),
    .T_TMO (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwr_up_req   (pwr_up_req),
    .pwr_dn_req   (pwr_dn_req),
    .vddq_ok_async(vddq_ok_async),
    .ring_en      (ring_en),
    .ret_n        (ret_n),
    .pad_oe_en    (pad_oe_en),
    .pwr_ack      (pwr_ack),
    .pwr_fault    (pwr_fault),
    .pwr_state    (pwr_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {pwr_state, ring_en, ret_n, pad_oe_en, pwr_ack, pwr_fault};

  task automatic push(input int c, input logic [7:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic check(input string n, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", n, act, req);
    end
  endtask

  task automatic wait_drain(input string n);
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d expected events never seen, required 0 (next %s)", n, q.size(),
               q[0].name);
      q.delete();
    end
  endtask

  // Monitor: every change of state/outputs must match the head of the queue.
  initial begin
    logic [7:0] last;
    exp_t       e;
    last = V_OFF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = V_OFF;
      end else if (obs !== last) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got %b at cycle %0d, required no change from %b",
                   obs, cyc, last);
        end else begin
          e = q.pop_front();
          if (obs !== e.vec || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d", e.name, obs, cyc,
                     e.vec, e.cyc);
          end
        end
        last = obs;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst_n         = 1'b0;
    pwr_up_req    = 1'b0;
    pwr_dn_req    = 1'b0;
    vddq_ok_async = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_vec", obs, V_OFF);
    check("reset_ret_n", {7'd0, ret_n}, 8'd0);
    check("reset_ring_en", {7'd0, ring_en}, 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal power-up
    b = cyc;
    pwr_up_req = 1'b1;
    push(b + 1, V_RAMP, "up_ramp");
    push(b + 9, V_RET, "up_ret");
    push(b + 13, V_ON, "up_on");
    wait_drain("up_drain");

    // Dropping pwr_up_req alone keeps ON
    @(negedge clk);
    pwr_up_req = 1'b0;
    repeat (5) @(negedge clk);
    check("on_hold", obs, V_ON);

    // Power-down with pwr_up_req also high: down dominates
    b = cyc;
    pwr_dn_req = 1'b1;
    pwr_up_req = 1'b1;
    push(b + 1, V_DNOE, "dn_oe");
    push(b + 3, V_DNRET, "dn_ret");
    push(b + 7, V_OFF, "dn_off");
    wait_drain("dn_drain");
    @(negedge clk);
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b0;
    repeat (2) @(negedge clk);
    check("off_idle", obs, V_OFF);

    // RAMP glitch after 5 good cycles restarts the settle count
    b = cyc;
    pwr_up_req = 1'b1;
    push(b + 1, V_RAMP, "glitch_ramp");
    push(b + 15, V_RET, "glitch_ret");
    push(b + 19, V_ON, "glitch_on");
    repeat (4) @(negedge clk);
    vddq_ok_async = 1'b0;
    @(negedge clk);
    vddq_ok_async = 1'b1;
    wait_drain("glitch_drain");

    // Supply loss in ON with a simultaneous pwr_dn_req
    @(negedge clk);
    b = cyc;
    vddq_ok_async = 1'b0;
    push(b + 3, V_FAULT, "loss_fault");
    push(b + 4, V_OFF, "loss_exit");
    repeat (2) @(negedge clk);
    pwr_dn_req = 1'b1;
    pwr_up_req = 1'b0;
    wait_drain("loss_drain");
    @(negedge clk);
    pwr_dn_req = 1'b0;
    repeat (3) @(negedge clk);

    // RAMP timeout with VDDQ never good
    b = cyc;
    pwr_up_req = 1'b1;
    push(b + 1, V_RAMP, "tmo_ramp");
    push(b + 21, V_FAULT, "tmo_fault");
    wait_drain("tmo_drain");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pwr_up_req = ~pwr_up_req;
      check("fault_hold", obs, V_FAULT);
    end
    @(negedge clk);
    b = cyc;
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b1;
    push(b + 1, V_OFF, "fault_clear");
    wait_drain("fault_drain");
    @(negedge clk);
    pwr_dn_req    = 1'b0;
    vddq_ok_async = 1'b1;
    repeat (3) @(negedge clk);

    // Async reset in the middle of DN_OE
    b = cyc;
    pwr_up_req = 1'b1;
    push(b + 1, V_RAMP, "pre_rst_ramp");
    push(b + 9, V_RET, "pre_rst_ret");
    push(b + 13, V_ON, "pre_rst_on");
    wait_drain("pre_rst_drain");
    @(negedge clk);
    b = cyc;
    pwr_dn_req = 1'b1;
    pwr_up_req = 1'b0;
    push(b + 1, V_DNOE, "pre_rst_dnoe");
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vec", obs, V_OFF);
    check("async_rst_ring_en", {7'd0, ring_en}, 8'd0);
    check("async_rst_ret_n", {7'd0, ret_n}, 8'd0);
    check("async_rst_pending", 8'(q.size()), 8'd0);
    repeat (2) @(negedge clk);
    b = cyc;
    pwr_dn_req = 1'b0;
    pwr_up_req = 1'b1;
    rst_n      = 1'b1;
    push(b + 1, V_RAMP, "post_rst_ramp");
    push(b + 10, V_RET, "post_rst_ret");
    push(b + 14, V_ON, "post_rst_on");
    wait_drain("post_rst_drain");
    repeat (2) @(negedge clk);
    check("final_on", obs, V_ON);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_ring_pwr_seq.md
Name: io_ring_pwr_seq

Overview:
- Digital-side sequencer for the EG 1.8 V IO ring: the controlling end of the IO supply/ground pad pair.
- Sequences ring enable, pad retention release and output-driver enable on power-up, and reverses that order on power-down.
- Monitors the synchronised VDDQ-good indicator from the ring level detector and forces a safe state if IO supply is lost.
- Sits in the always-on domain between the power management unit and the pad ring control bus.

Parameters:
- CNT_W, 16, width of the settle/timeout counter.
- T_RING, 1000, clk cycles VDDQ must stay good before retention release (1..2^CNT_W-1).
- T_RET, 64, clk cycles between retention change and next step (1..2^CNT_W-1).
- T_OE, 16, clk cycles after driver disable before retention assert (1..2^CNT_W-1).
- T_TMO, 4000, max clk cycles in RAMP waiting for VDDQ good before fault (> T_RING).

Ports:
- clk  in  1  always-on clock.
- rst_n  in  1  asynchronous active-low reset.
- pwr_up_req  in  1  level request: IO ring on.
- pwr_dn_req  in  1  level request: IO ring off; dominates pwr_up_req.
- vddq_ok_async  in  1  VDDQ-good from level detector, asynchronous.
- ring_en  out  1  enables IO ring supply switch/bias.
- ret_n  out  1  0 = pads held in retention, 1 = released.
- pad_oe_en  out  1  global output-driver enable.
- pwr_ack  out  1  high only while in ON.
- pwr_fault  out  1  sticky fault flag.
- pwr_state  out  3  current state encoding.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0, ret_n=0, state OFF.
  - Synchroniser flops cleared.
- vddq_ok_async passes through a 2-flop synchroniser to vddq_ok_s. All decisions use vddq_ok_s.
- States and encodings:
  - OFF=0
  - RAMP=1
  - RET=2
  - ON=3
  - DN_OE=4
  - DN_RET=5
  - FAULT=6
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - OFF: ring_en=0, ret_n=0, oe=0
  - RAMP: ring_en=1, ret_n=0, oe=0
  - RET: ring_en=1, ret_n=1, oe=0
  - ON: ring_en=1, ret_n=1, oe=1, pwr_ack=1
  - DN_OE: ring_en=1, ret_n=1, oe=0
  - DN_RET: ring_en=1, ret_n=0, oe=0
  - FAULT: all 0, pwr_fault=1
- Transitions:
  - OFF:
    - pwr_up_req & !pwr_dn_req -> RAMP; counter cleared.
  - RAMP:
    - The counter counts cycles with vddq_ok_s=1 and clears to 0 on any cycle with vddq_ok_s=0.
    - When the counter reaches T_RING -> RET.
    - A separate timeout counter runs from RAMP entry; reaching T_TMO -> FAULT.
    - pwr_dn_req -> OFF immediately.
  - RET:
    - After T_RET cycles -> ON.
    - pwr_dn_req -> DN_RET.
  - ON:
    - pwr_dn_req -> DN_OE.
    - Deassertion of pwr_up_req alone does not leave ON.
  - DN_OE:
    - After T_OE cycles -> DN_RET.
  - DN_RET:
    - After T_RET cycles -> OFF.
  - FAULT:
    - Exit to OFF only on pwr_dn_req=1; pwr_fault clears on that exit.
  - Any state except OFF and FAULT:
    - vddq_ok_s=0 while in RET, ON, DN_OE or DN_RET -> FAULT.
    - This has priority over all requests.
- Counters:
  - Saturating, CNT_W bits.
  - Reloaded to 0 on every state change.
  - A "count reached" compare uses ==, evaluated on the edge where the count equals the parameter.
- Simultaneous events:
  - vddq loss beats pwr_dn_req, which beats pwr_up_req.
  - pwr_up_req during DN_OE or DN_RET is ignored; the power-down sequence always completes before OFF.
  - pwr_up_req held high in OFF restarts the sequence the cycle after OFF is entered.
- Reset mid-sequence: all outputs drop to their reset values asynchronously, regardless of state. No ordering is guaranteed on reset; the pad cells tolerate this.

Test Plan:
- Nominal power-up (T_RING=8, T_RET=4, vddq_ok high from cycle 0), pwr_up_req=1:
  - ring_en rises at cycle 1.
  - ret_n rises 8 cycles after vddq_ok_s is high.
  - pad_oe_en and pwr_ack rise 4 cycles later.
  - pwr_state follows 0->1->2->3.
- Power-down from ON (T_OE=2, T_RET=4), pwr_dn_req=1:
  - pad_oe_en and pwr_ack fall next edge.
  - ret_n falls 2 cycles later.
  - ring_en falls 4 cycles after that.
  - State ends at 0.
- RAMP glitch: vddq_ok low for 1 cycle at RAMP count 5 with T_RING=8:
  - Counter restarts.
  - RET is entered 8 good cycles after the glitch, not 3.
- RAMP timeout: vddq_ok held 0 with T_TMO=20:
  - FAULT at cycle 20 of RAMP.
  - pwr_fault=1 and all enables 0.
  - pwr_up_req toggling has no effect.
  - pwr_dn_req returns to OFF with pwr_fault=0.
- Supply loss in ON: drop vddq_ok_async:
  - FAULT within 3 cycles (2 synchroniser + 1).
  - pad_oe_en, ret_n and ring_en all 0.
  - A pwr_dn_req asserted in the same cycle does not cause DN_OE.
- Async reset asserted in the middle of DN_OE: all outputs go to 0 immediately, with no clock edge required. After release with pwr_up_req=1, a full power-up sequence runs.
